// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a five-stage multicycle RISC-V-style datapath. It sequences
// FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK) for five instruction
// classes, handshakes with memory through mem_ready_i, and parks in a sticky
// ERROR state on a memory timeout or an illegal opcode.
//
// Ports
//   clock_i         single clock, rising edge
//   reset_i         synchronous, active-high reset
//   start_i         run instructions while high (sampled in IDLE / at end)
//   opcode_i[6:0]   instr[6:0], looked at in DECODE only
//   mem_ready_i     memory handshake, meaningful in FETCH / MEMORY only
//   mem_read_o, mem_write_o, ir_write_o, pc_write_o   memory / IR / PC strobes
//   alu_src_o       ALU operand B: 0 = register 2, 1 = immediate
//   mem_to_reg_o    write-back mux: 0 = ALU result, 1 = read data
//   reg_write_o, branch_o                register write / branch compare
//   alu_op_o[1:0]   00 add, 01 subtract-compare, 10 funct-decoded
//   state_o[2:0]    current state code
//   instr_done_o    one-cycle completion pulse
//   error_o         sticky fault flag
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15  // 1..255
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       alu_src_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       branch_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] state_o,
  output logic       instr_done_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd6,
    S_INVALID   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [7:0] wait_q, wait_d;

  cls_e       op_cls;
  logic       op_legal;
  logic [7:0] wait_inc;
  logic       timed_out;
  state_e     next_instr;

  // Opcode classification, only consumed in DECODE.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    op_legal = 1'b1;
    op_cls   = CLS_R;
    case (opcode_i)
      OP_R:      op_cls = CLS_R;
      OP_I:      op_cls = CLS_I;
      OP_LOAD:   op_cls = CLS_LOAD;
      OP_STORE:  op_cls = CLS_STORE;
      OP_BRANCH: op_cls = CLS_BRANCH;
      default:   op_legal = 1'b0;
    endcase
  end

  // wait_inc is the number of not-ready cycles including this one; reaching
  // MEM_TIMEOUT without mem_ready means the access gave up. A ready in that
  // same cycle still completes, because the ready branch is tested first.
  assign wait_inc   = wait_q + 8'd1;
  assign timed_out  = !mem_ready_i && (wait_inc == TIMEOUT_CNT);
  assign next_instr = start_i ? S_FETCH : S_IDLE;

  // Next-state logic. The counter falls back to zero in every cycle that is
  // not a stalled wait, so it is always clear on entry to FETCH / MEMORY.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i)    state_d = S_DECODE;
        else if (timed_out) state_d = S_ERROR;
        else                wait_d  = wait_inc;
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXECUTE;
          cls_d   = op_cls;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          CLS_BRANCH:          state_d = next_instr;
          CLS_LOAD, CLS_STORE: state_d = S_MEMORY;
          default:             state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready_i)    state_d = (cls_q == CLS_LOAD) ? S_WRITEBACK : next_instr;
        else if (timed_out) state_d = S_ERROR;
        else                wait_d  = wait_inc;
      end
      S_WRITEBACK: state_d = next_instr;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;  // unused code 7
    endcase
  end

  always_ff @(posedge clock_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of ordering.
    if (reset_i) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_R;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
    end
  end

  // Output decode from state, latched class and mem_ready only. pc_write and
  // the STORE completion pulse must fire in the handshake cycle itself, so
  // these outputs are decoded rather than registered.
  always_comb begin
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    branch_o     = 1'b0;
    alu_op_o     = 2'b00;
    instr_done_o = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        ir_write_o = 1'b1;
        pc_write_o = mem_ready_i;
      end
      S_EXECUTE: begin
        case (cls_q)
          CLS_R:      alu_op_o = 2'b10;
          CLS_I: begin
            alu_src_o = 1'b1;
            alu_op_o  = 2'b10;
          end
          CLS_LOAD, CLS_STORE: alu_src_o = 1'b1;
          CLS_BRANCH: begin
            alu_op_o     = 2'b01;
            branch_o     = 1'b1;
            instr_done_o = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        alu_src_o = 1'b1;
        if (cls_q == CLS_LOAD) begin
          mem_read_o = 1'b1;
        end else begin
          mem_write_o  = 1'b1;
          instr_done_o = mem_ready_i;
        end
      end
      S_WRITEBACK: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (cls_q == CLS_LOAD);
        instr_done_o = 1'b1;
      end
      S_ERROR: error_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Builds, per instruction, the expected cycle-by-cycle trace of inputs and
// outputs from the instruction's class and its memory wait lengths, then
// replays the trace into the DUT and compares every output every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TO = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_ERR = 3'd6;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  logic [6:0] opcode;
  logic       mem_read, mem_write, ir_write, pc_write, alu_src, mem_to_reg;
  logic       reg_write, branch, instr_done, error;
  logic [1:0] alu_op;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .start_i      (start),
    .opcode_i     (opcode),
    .mem_ready_i  (mem_ready),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .alu_src_o    (alu_src),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .branch_o     (branch),
    .alu_op_o     (alu_op),
    .state_o      (state),
    .instr_done_o (instr_done),
    .error_o      (error)
  );

  // One cycle: inputs to apply and outputs required in that cycle.
  typedef struct packed {
    logic       rst, start, rdy;
    logic [6:0] op;
    logic [2:0] st;
    logic       mr, mw, irw, pcw, asrc, m2r, rw, br;
    logic [1:0] aop;
    logic       done, err;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [14:0] exp_vec(input cyc_t c);
    return {c.st, c.mr, c.mw, c.irw, c.pcw, c.asrc, c.m2r, c.rw, c.br, c.aop, c.done, c.err};
  endfunction

  // A cycle in state st with all outputs low and don't-care inputs randomised.
  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c       = '0;
    c.st    = st;
    c.start = 1'($urandom);
    c.rdy   = 1'($urandom);
    c.op    = 7'($urandom);
    return c;
  endfunction

  function automatic logic [6:0] legal_op(input int k);
    case (k)
      0: return OP_R;
      1: return OP_I;
      2: return OP_LOAD;
      3: return OP_STORE;
      default: return OP_BRANCH;
    endcase
  endfunction

  function automatic logic [6:0] illegal_op();
    logic [6:0] op;
    op = 7'($urandom);
    while (op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH)
      op = 7'($urandom);
    return op;
  endfunction

  // ---------------- reference model: trace generators ----------------------
  task automatic gen_idle(input int n, input bit go);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(ST_IDLE); c.start = 1'b0; q.push_back(c);
    end
    if (go) begin
      c = blank(ST_IDLE); c.start = 1'b1; q.push_back(c);
    end
  endtask

  // One instruction from FETCH onwards. A wait of TO or more means memory
  // never answers: TO stalled cycles are emitted and the trace stops (ERROR
  // follows). rst_at >= 0 asserts reset in that MEMORY wait cycle and stops.
  // cont is the start level seen in the instruction's last cycle.
  task automatic gen_instr(input logic [6:0] op, input int fwait, input int mwait,
                           input bit cont, input int rst_at);
    cyc_t c;
    bit is_r, is_i, is_ld, is_st, is_br;
    is_r  = (op == OP_R);
    is_i  = (op == OP_I);
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    is_br = (op == OP_BRANCH);
    for (int i = 0; i < ((fwait < TO) ? fwait : TO); i++) begin
      c = blank(ST_FETCH); c.rdy = 1'b0; c.mr = 1'b1; c.irw = 1'b1; q.push_back(c);
    end
    if (fwait >= TO) return;
    c = blank(ST_FETCH); c.rdy = 1'b1; c.mr = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
    q.push_back(c);
    c = blank(ST_DECODE); c.op = op; q.push_back(c);
    if (!(is_r || is_i || is_ld || is_st || is_br)) return;
    c = blank(ST_EXEC);
    c.asrc = is_ld | is_st | is_i;
    c.aop  = is_br ? 2'b01 : ((is_r | is_i) ? 2'b10 : 2'b00);
    if (is_br) begin
      c.br = 1'b1; c.done = 1'b1; c.start = cont; q.push_back(c);
      return;
    end
    q.push_back(c);
    if (is_ld || is_st) begin
      for (int i = 0; i < ((mwait < TO) ? mwait : TO); i++) begin
        c = blank(ST_MEM); c.rdy = 1'b0; c.asrc = 1'b1; c.mr = is_ld; c.mw = is_st;
        if (i == rst_at) begin
          c.rst = 1'b1; c.start = 1'b1; q.push_back(c);
          return;
        end
        q.push_back(c);
      end
      if (mwait >= TO) return;
      c = blank(ST_MEM); c.rdy = 1'b1; c.asrc = 1'b1; c.mr = is_ld; c.mw = is_st;
      if (is_st) begin
        c.done = 1'b1; c.start = cont; q.push_back(c);
        return;
      end
      q.push_back(c);
    end
    c = blank(ST_WB); c.rw = 1'b1; c.m2r = is_ld; c.done = 1'b1; c.start = cont;
    q.push_back(c);
  endtask

  // n sticky ERROR cycles, then a reset cycle; the DUT is IDLE afterwards.
  task automatic gen_error(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(ST_ERR); c.err = 1'b1; q.push_back(c);
    end
    c = blank(ST_ERR); c.err = 1'b1; c.rst = 1'b1; c.start = 1'b1; c.rdy = 1'b1;
    q.push_back(c);
  endtask

  // Apply one cycle's inputs just after the edge, sample mid-cycle.
  task automatic drive_sample(input cyc_t c, output logic [14:0] obs);
    @(posedge clk);
    #1;
    reset     = c.rst;
    start     = c.start;
    mem_ready = c.rdy;
    opcode    = c.op;
    @(negedge clk);
    obs = {state, mem_read, mem_write, ir_write, pc_write, alu_src, mem_to_reg,
           reg_write, branch, alu_op, instr_done, error};
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    c = blank(ST_IDLE); c.rst = 1'b1; c.start = 1'b1; c.rdy = 1'b1; q.push_back(c);
    gen_idle(2, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL reset cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_r_type();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    gen_idle(1, 1'b1);
    gen_instr(OP_R, 0, 0, 1'b1, -1);
    gen_instr(OP_R, 0, 0, 1'b1, -1);
    gen_instr(OP_R, 2, 0, 1'b0, -1);
    gen_idle(1, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL r_type cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_load_store_branch();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    gen_idle(0, 1'b1);
    gen_instr(OP_LOAD, 0, 3, 1'b1, -1);
    gen_instr(OP_STORE, 1, 2, 1'b1, -1);
    gen_instr(OP_BRANCH, 0, 0, 1'b0, -1);
    gen_idle(2, 1'b1);
    gen_instr(OP_I, 0, 0, 1'b1, -1);
    gen_instr(OP_STORE, 0, 0, 1'b0, -1);
    gen_idle(1, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL ld_st_br cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_random();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    bit cont;
    int fw, mw;
    gen_idle(1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      fw   = ($urandom_range(0, 4) == 0) ? TO - 1 : $urandom_range(0, 3);
      mw   = ($urandom_range(0, 4) == 0) ? TO - 1 : $urandom_range(0, 3);
      cont = (k == 29) ? 1'b0 : 1'($urandom);
      gen_instr(legal_op($urandom_range(0, 4)), fw, mw, cont, -1);
      if (!cont) gen_idle($urandom_range(0, 2), k != 29);
    end
    gen_idle(1, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL random cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_fetch_timeout();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    gen_idle(0, 1'b1);
    gen_instr(OP_R, TO - 1, 0, 1'b1, -1);   // ready on the last allowed cycle
    gen_instr(OP_R, TO, 0, 1'b1, -1);       // never ready -> ERROR
    gen_error(6);
    gen_idle(2, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL fetch_timeout cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_mem_timeout();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    gen_idle(0, 1'b1);
    gen_instr(OP_LOAD, 0, TO - 1, 1'b1, -1);
    gen_instr(OP_STORE, 0, TO, 1'b1, -1);
    gen_error(3);
    gen_idle(1, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL mem_timeout cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    gen_idle(0, 1'b1);
    gen_instr(7'b1111111, 0, 0, 1'b1, -1);
    gen_error(4);
    gen_idle(1, 1'b1);
    gen_instr(illegal_op(), 1, 0, 1'b1, -1);
    gen_error(2);
    gen_idle(2, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL illegal cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  task automatic test_reset_mid_memory();
    cyc_t c;
    logic [14:0] obs;
    int n = 0;
    gen_idle(0, 1'b1);
    gen_instr(OP_LOAD, 0, TO - 1, 1'b1, 9);  // reset after 9 stalled cycles
    gen_idle(1, 1'b1);
    // The counter must restart from zero: full-length waits still complete.
    gen_instr(OP_STORE, TO - 1, TO - 1, 1'b1, -1);
    gen_instr(OP_BRANCH, 0, 0, 1'b0, -1);
    gen_idle(3, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front();
      drive_sample(c, obs);
      total++;
      if (obs !== exp_vec(c)) $display("FAIL reset_mid_mem cyc %0d: got %b want %b", n, obs, exp_vec(c));
      else passed++;
      n++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 7'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_r_type();
    test_load_store_branch();
    test_random();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_memory();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max wait cycles for mem_ready in FETCH/MEMORY before ERROR (range 1..255).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level: run instructions while high; sampled in IDLE and at instruction end.
REQ-005 opcode  input  7  instr[6:0] from instruction register; sampled in DECODE only.
REQ-006 mem_ready  input  1  memory handshake: access completes in a cycle where mem_ready=1 and mem_read or mem_write=1.
REQ-007 mem_read, mem_write  output  1 each  memory access requests.
REQ-008 ir_write, pc_write  output  1 each  instruction-register load / PC update strobes.
REQ-009 alu_src  output  1  selector for ALU operand-B mux: 0 = register 2, 1 = immediate.
REQ-010 mem_to_reg  output  1  selector for write-back mux: 0 = ALU result, 1 = read data.
REQ-011 reg_write, branch  output  1 each  register-file write enable / branch-compare strobe.
REQ-012 alu_op  output  2  00 add (load/store), 01 subtract-compare (branch), 10 funct-decoded (R/I-ALU).
REQ-013 state  output  3  current state code; instr_done output 1 one-cycle completion pulse; error output 1 sticky fault.

Function
REQ-014 State codes SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6; code 7 SHALL go to ERROR next cycle.
REQ-015 Legal opcodes SHALL be R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011; class latched into an internal register on the DECODE->EXECUTE transition.
REQ-016 IDLE: all outputs 0; start=1 -> FETCH next cycle.
REQ-017 FETCH: mem_read=1, ir_write=1; on mem_ready=1: pc_write=1 same cycle, -> DECODE.
REQ-018 DECODE: legal opcode -> EXECUTE; illegal -> ERROR.
REQ-019 EXECUTE: alu_src=1 for LOAD/STORE/I-ALU, 0 for R/BRANCH; alu_op per REQ-012; BRANCH: branch=1, instruction ends; LOAD/STORE -> MEMORY; R/I-ALU -> WRITEBACK.
REQ-020 MEMORY: alu_src=1, alu_op=00 held; LOAD: mem_read=1, on mem_ready -> WRITEBACK; STORE: mem_write=1, on mem_ready instruction ends.
REQ-021 WRITEBACK: reg_write=1 for exactly one cycle; mem_to_reg=1 for LOAD, 0 otherwise; instruction ends.
REQ-022 Instruction end: instr_done=1 in that same cycle; next state FETCH if start=1, else IDLE.
REQ-023 Wait counter (8 bits) SHALL clear on entry to FETCH/MEMORY, increment each cycle mem_ready=0; when it equals MEM_TIMEOUT with mem_ready=0 -> ERROR next cycle.
REQ-024 mem_ready=1 in the cycle the counter reaches MEM_TIMEOUT SHALL complete normally (ready wins).
REQ-025 mem_ready outside FETCH/MEMORY SHALL be ignored; start deassertion mid-instruction SHALL NOT abort it.
REQ-026 ERROR: error=1, all other control outputs 0; exit only by reset.
REQ-027 Outputs SHALL be decoded from state, latched class and mem_ready only; no output depends on opcode outside DECODE.
REQ-028 mem_read and mem_write SHALL never be 1 in the same cycle.

Reset
REQ-029 reset=1 at a rising edge SHALL force state=IDLE, wait counter=0, latched class=R, error=0, all outputs 0 in the following cycle, from any state including mid-handshake and ERROR.
REQ-030 Reset SHALL override start and mem_ready in the same cycle.

Verification
REQ-031 start=1, mem_ready=1 always, opcode=0110011 -> states 1,2,3,5; reg_write=1 in state 5 with mem_to_reg=0; instr_done pulse; back to FETCH.
REQ-032 LOAD 0000011, mem_ready delayed 3 cycles in MEMORY -> mem_read held 4 cycles, alu_src=1, then WRITEBACK with mem_to_reg=1, reg_write=1 once.
REQ-033 STORE 0100011 -> mem_write=1 in MEMORY, instr_done at mem_ready, reg_write never 1; BRANCH 1100011 -> alu_op=01, branch=1, done in EXECUTE.
REQ-034 MEM_TIMEOUT=15, mem_ready=0 in FETCH -> ERROR after 15 wait cycles, error=1 sticky; mem_ready=1 on the 15th cycle -> DECODE instead.
REQ-035 opcode=1111111 in DECODE -> ERROR; then reset=1 for one cycle -> state=0, all outputs 0.
REQ-036 reset asserted during MEMORY with mem_read=1 -> next cycle mem_read=0, state=IDLE; start=0 at instruction end -> IDLE with instr_done=1 once.
